// File: rtl/m_wb_pipe_buffer_pkg.sv
// Shared definitions for the Memory->Writeback stage buffer.
//   - default payload field widths
//   - mwb_payload_t : packed view of one M-stage result at default widths
//   - mwb_count_width() : width of an occupancy counter able to hold 0..depth
package m_wb_pipe_buffer_pkg;

  localparam int unsigned MWB_WORD_SIZE       = 32;
  localparam int unsigned MWB_INSTR_TYPE_SZ   = 2;
  localparam int unsigned MWB_ROB_ENTRY_WIDTH = 3;
  localparam int unsigned MWB_DEFAULT_DEPTH   = 2;

  typedef struct packed {
    logic [MWB_INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [MWB_WORD_SIZE-1:0]       pc;
    logic                           exception;
    logic [MWB_WORD_SIZE-1:0]       virtual_addr_exception;
    logic [MWB_WORD_SIZE-1:0]       load_data;
    logic [MWB_ROB_ENTRY_WIDTH-1:0] rob_id;
  } mwb_payload_t;

  function automatic int unsigned mwb_count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned MWB_COUNT_W = mwb_count_width(MWB_DEFAULT_DEPTH);

endpackage

// File: rtl/m_wb_pipe_buffer_ptr_wrap_counter.sv
// Modulo-DEPTH pointer with increment and clear.
// Ports:
//   clk      rising-edge clock
//   i_rst    synchronous active-high reset (pointer -> 0)
//   i_clear  synchronous clear (pointer -> 0), same effect as reset
//   i_inc    advance pointer by one, wrapping DEPTH-1 -> 0
//   o_ptr    current pointer value
module ptr_wrap_counter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  // Explicit compare against DEPTH-1 so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/m_wb_pipe_buffer.sv
// Memory->Writeback stage buffer: DEPTH-entry FIFO of M-stage results with
// valid/ready handshake on both sides, full flush, occupancy count and a
// sticky exception summary.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      discard all buffered entries
//   in_valid / in_ready        M-side handshake (in_ready from registered state only)
//   instruction_type, pc, exception, virtual_addr_exception, load_data, rob_id
//                              M-side payload
//   out_valid / out_ready      WB-side handshake
//   *_out                      head payload, forced to 0 while out_valid=0
//   count                      occupancy 0..DEPTH
//   exception_pending          some buffered entry carries exception=1
module m_wb_pipe_buffer
  import m_wb_pipe_buffer_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = MWB_WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ   = MWB_INSTR_TYPE_SZ,
  parameter int unsigned ROB_ENTRY_WIDTH = MWB_ROB_ENTRY_WIDTH,
  parameter int unsigned DEPTH           = MWB_DEFAULT_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]           instruction_type,
  input  logic [WORD_SIZE-1:0]               pc,
  input  logic                               exception,
  input  logic [WORD_SIZE-1:0]               virtual_addr_exception,
  input  logic [WORD_SIZE-1:0]               load_data,
  input  logic [ROB_ENTRY_WIDTH-1:0]         rob_id,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [INSTR_TYPE_SZ-1:0]           instruction_type_out,
  output logic [WORD_SIZE-1:0]               pc_out,
  output logic                               exception_out,
  output logic [WORD_SIZE-1:0]               virtual_addr_exception_out,
  output logic [WORD_SIZE-1:0]               load_data_out,
  output logic [ROB_ENTRY_WIDTH-1:0]         rob_id_out,
  output logic [mwb_count_width(DEPTH)-1:0]  count,
  output logic                               exception_pending
);

  localparam int unsigned CW = mwb_count_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic                       exception;
    logic [WORD_SIZE-1:0]       virtual_addr_exception;
    logic [WORD_SIZE-1:0]       load_data;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic [DEPTH-1:0] r_exc;

  logic [PW-1:0]   w_rd_ptr;
  logic [PW-1:0]   w_wr_ptr;
  logic            w_push;
  logic            w_pop;
  entry_t          w_in;
  entry_t          w_head;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_in = '{
    instruction_type:       instruction_type,
    pc:                     pc,
    exception:              exception,
    virtual_addr_exception: virtual_addr_exception,
    load_data:              load_data,
    rob_id:                 rob_id
  };

  ptr_wrap_counter #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (flush),
    .i_inc   (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  ptr_wrap_counter #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (flush),
    .i_inc   (w_push),
    .o_ptr   (w_wr_ptr)
  );

  // Payload storage is not reset; the output mask hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !reset) begin
      r_mem[w_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Push and pop can never hit the same slot in one cycle: that would need
  // count to be both below DEPTH and zero-or-DEPTH at once.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_exc <= '0;
    end else begin
      if (w_pop) begin
        r_exc[w_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_exc[w_wr_ptr] <= exception;
      end
    end
  end

  assign exception_pending = |r_exc;
  assign count             = r_count;

  assign w_head = out_valid ? r_mem[w_rd_ptr] : '0;

  assign instruction_type_out       = w_head.instruction_type;
  assign pc_out                     = w_head.pc;
  assign exception_out              = w_head.exception;
  assign virtual_addr_exception_out = w_head.virtual_addr_exception;
  assign load_data_out              = w_head.load_data;
  assign rob_id_out                 = w_head.rob_id;

endmodule

// File: doc/m_wb_pipe_buffer.md
Name: m_wb_pipe_buffer

Overview:
- Parametrised Memory→Writeback stage buffer. It is the successor to the single-entry M/WB register.
- Holds up to DEPTH in-flight M-stage results in FIFO order, with a valid/ready handshake on both sides, so a WB stall no longer back-pressures M on the very next cycle.
- Provides a full flush for ROB recovery, an occupancy count, and a sticky exception summary for the ROB.

Parameters:
- WORD_SIZE, 32, width of pc, load data and exception virtual address
- INSTR_TYPE_SZ, 2, width of instruction type code
- ROB_ENTRY_WIDTH, 3, width of ROB tag
- DEPTH, 2, number of buffered entries; must be ≥2; need not be a power of two

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all buffered entries (ROB recovery)
- in_valid  in  1  M stage presents a result
- in_ready  out  1  buffer accepts this cycle
- instruction_type  in  INSTR_TYPE_SZ  payload
- pc  in  WORD_SIZE  payload
- exception  in  1  payload
- virtual_addr_exception  in  WORD_SIZE  payload
- load_data  in  WORD_SIZE  payload
- rob_id  in  ROB_ENTRY_WIDTH  payload
- out_ready  in  1  WB consumes head (equivalent to !stall)
- out_valid  out  1  head entry is valid
- instruction_type_out, pc_out, exception_out, virtual_addr_exception_out, load_data_out, rob_id_out  out  (same widths)  head payload
- count  out  $clog2(DEPTH+1)  occupancy
- exception_pending  out  1  some buffered entry has exception=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - count=0, read and write pointers=0.
  - out_valid=0, exception_pending=0, in_ready=1.
  - All payload outputs read 0 while out_valid=0.
- Handshake rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = (count < DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Storage and pointers:
  - Payload is written at the write pointer on push.
  - Head outputs are a combinational read of the entry at the read pointer, masked to 0 when out_valid=0.
- Latency:
  - An entry pushed at edge N is visible at the outputs after edge N (one-cycle latency), including when the buffer was empty. There is no same-cycle bypass.
- Pointer wrap: each pointer increments modulo DEPTH. When DEPTH is not a power of two, the pointer wraps from DEPTH-1 to 0.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever count is strictly between 0 and DEPTH.
- Full: in_ready=0, so no push can occur. A pop while full frees a slot; in_ready rises the following cycle.
- Empty: out_valid=0, so out_ready is ignored and count never underflows.
- Flush:
  - Priority: reset > flush > push/pop.
  - On flush, count and both pointers go to 0 at that edge. Any simultaneous push is dropped and any simultaneous pop is irrelevant.
  - Stored payload need not be cleared; the output masking hides it.
- Reset mid-operation: identical to flush, with all outputs at reset values the next cycle.
- exception_pending:
  - OR of the exception bits of all valid entries, held in a per-entry valid-exception bit vector.
  - A set bit is cleared when its entry pops or on flush/reset.
  - It is registered state, so it updates one edge after push/pop.
- Input stability: while in_valid=1 && in_ready=0, the payload is ignored. The producer holds it.

Decomposition:
- Shared package: WORD_SIZE, INSTR_TYPE_SZ and ROB_ENTRY_WIDTH defaults (existing defines), a packed mwb_payload_t struct covering the six payload fields, and a helper constant for the count width.
- One sub-module is natural: ptr_wrap_counter (parametrised modulo-DEPTH pointer with increment and clear). It is instantiated twice, for the read and write pointers.

Test Plan:
- After reset, push pc=0x100, rob_id=1, out_ready=0 → next cycle out_valid=1, pc_out=0x100, count=1, in_ready=1. Push pc=0x104 → count=2, in_ready=0, pc_out still 0x100.
- Full (DEPTH=2), out_ready=1 for one cycle → pc_out=0x104 and count=1 after the edge; in_ready=1 the same cycle. A further pop gives out_valid=0 and all payload outputs 0.
- Continuous in_valid=1, out_ready=1 streaming pcs 0x200..0x21C with DEPTH=3 → count stays at 1, the output order equals the input order with no loss, and the pointers wrap 2→0.
- Push an entry with exception=1, virtual_addr_exception=0xDEAD0000 behind a normal entry → exception_pending=1 after the push. It stays 1 after the normal entry pops and drops to 0 the cycle after the faulting entry pops.
- With count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, exception_pending=0, and the pushed entry is absent.
- With count=2, assert reset → next cycle all outputs are at reset values. Push after reset release → the entry appears normally with count=1.
